// File: rtl/viterbi_frame_ctrl.sv
// Frame controller between the serial coded-bit channel and the Viterbi decoder core:
// collects frames, runs the start/done handshake and serialises the decoder results.
module viterbi_frame_ctrl #(
  parameter int CODE_W = 14,
  parameter int DATA_W = CODE_W / 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              in_vld,
  input  logic              dec_done,
  input  logic [CODE_W-1:0] dec_code,
  input  logic [DATA_W-1:0] dec_data,
  output logic [CODE_W-1:0] frame_out,
  output logic              dec_start,
  output logic              code_out,
  output logic              code_vld,
  output logic              data_out,
  output logic              data_stb,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              busy,
  output logic              overrun
);

  localparam int BCNT_W = $clog2(CODE_W);
  localparam logic [BCNT_W-1:0] LAST = BCNT_W'(CODE_W - 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t              state;
  logic [CODE_W-1:0]   col_sr;
  logic [BCNT_W-1:0]   bcnt;
  logic [CODE_W-1:0]   code_sr;
  logic [DATA_W-1:0]   data_sr;
  logic [BCNT_W-1:0]   scnt;
  logic                run;

  logic [CODE_W-1:0]   next_word;
  logic                complete;
  logic                load;
  logic                accept;

  assign next_word = {in_bit, col_sr[CODE_W-1:1]};
  assign complete  = in_vld && (bcnt == LAST);
  assign load      = dec_done && (state == WAIT);
  // A done on the completion edge frees the decoder first, so that frame is still taken.
  assign accept    = complete && ((state == IDLE) || dec_done);

  assign busy     = (state == WAIT);
  assign code_out = code_sr[0];
  assign code_vld = run;
  assign data_out = data_sr[DATA_W-1];
  assign data_stb = run && !scnt[0];

  // Collector, handshake FSM, frame bookkeeping and serialiser.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      col_sr    <= '0;
      bcnt      <= '0;
      frame_out <= '0;
      dec_start <= 1'b0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      code_sr   <= '0;
      data_sr   <= '0;
      scnt      <= '0;
      run       <= 1'b0;
    end else begin
      dec_start <= accept;

      if (in_vld) begin
        col_sr <= next_word;
        bcnt   <= (bcnt == LAST) ? '0 : bcnt + BCNT_W'(1);
      end

      if (accept) begin
        frame_out <= next_word;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end

      case (state)
        IDLE:    if (accept) state <= WAIT;
        WAIT:    if (dec_done && !accept) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Reload during the final run cycle is a clean back-to-back handoff.
      if ((complete && !accept) || (load && run && (scnt != LAST)))
        overrun <= 1'b1;

      if (load) begin
        code_sr <= dec_code;
        data_sr <= dec_data;
        scnt    <= '0;
        run     <= 1'b1;
      end else if (run) begin
        code_sr <= {code_sr[0], code_sr[CODE_W-1:1]};
        if (scnt[0])
          data_sr <= {data_sr[DATA_W-2:0], data_sr[DATA_W-1]};
        scnt <= scnt + BCNT_W'(1);
        if (scnt == LAST)
          run <= 1'b0;
      end
    end
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Parametrised frame controller that sits between the serial coded-bit channel and the Viterbi decoder core. It deserialises coded bits into frames of CODE_W bits, hands each frame to the decoder with a start/done handshake, and serialises the decoder's corrected codeword and decoded data back out. It replaces the fixed-latency, free-running 14-bit controller with input flow control, a variable-latency decoder handshake, overrun detection and a frame counter.

## Interface
- CODE_W, 14, coded bits per frame; must be even, ≥4.
- DATA_W, CODE_W/2, decoded bits per frame; must equal CODE_W/2.
- CNT_W, 8, frame counter width.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_bit  in  1  serial coded bit.
- in_vld  in  1  in_bit valid this cycle.
- dec_done  in  1  decoder result valid (1-cycle pulse).
- dec_code  in  CODE_W  corrected codeword from decoder.
- dec_data  in  DATA_W  decoded data from decoder.
- frame_out  out  CODE_W  last accepted frame, first received bit in bit 0.
- dec_start  out  1  1-cycle pulse, frame_out newly valid.
- code_out  out  1  serial corrected codeword, LSB first.
- code_vld  out  1  code_out valid.
- data_out  out  1  serial decoded data, MSB first, each bit held 2 cycles.
- data_stb  out  1  high on first cycle of each data_out bit.
- frame_cnt  out  CNT_W  accepted frames, wraps modulo 2^CNT_W.
- busy  out  1  decoder handshake outstanding (WAIT).
- overrun  out  1  sticky error flag.

## Operation
- Collector: on in_vld=1, shift register takes in_bit at MSB and shifts right; bit counter bcnt increments 0..CODE_W-1 and wraps. in_vld=0 holds register and bcnt.
- Frame completion: in_vld=1 with bcnt=CODE_W-1.
  - If handshake FSM is IDLE: frame_out loads the completed word (including the current bit), dec_start pulses, frame_cnt increments, FSM → WAIT.
  - If FSM is WAIT: frame dropped (frame_out, frame_cnt unchanged, no dec_start), overrun set. bcnt still wraps to 0.
- Handshake FSM: IDLE → WAIT on accepted frame; WAIT → IDLE on dec_done=1. dec_done in IDLE ignored (no load, no flag). busy = (state==WAIT).
- Serialiser: on dec_done in WAIT, load code shift register with dec_code and data shift register with dec_data, scnt=0, run for CODE_W cycles.
  - code_out = code_sr[0]; rotate right every run cycle; code_vld=1 during run.
  - data_out = data_sr[DATA_W-1]; rotate left after odd scnt; data_stb=1 when run and scnt even.
  - dec_done during run: reload, restart at scnt=0, set overrun.
- overrun cleared only by reset.

## Timing
- Reset: all registers 0; frame_out=0, dec_start=0, code_out=0, code_vld=0, data_out=0, data_stb=0, frame_cnt=0, busy=0, overrun=0, FSM IDLE, bcnt=0. Reset mid-frame discards partial frame and any run.
- Completion sampled at edge N → frame_out valid and dec_start=1 for the cycle after N.
- dec_done sampled at edge M → code_vld=1, code_out=dec_code[0], data_out=dec_data[DATA_W-1], data_stb=1 in the cycle after M; code_out=dec_code[k] k cycles later; code_vld drops after CODE_W cycles.
- Frame completion and dec_done at the same edge while WAIT: dec_done returns FSM to IDLE first; frame accepted, no overrun, FSM ends in WAIT.
- dec_done at the edge ending the last run cycle is a fresh load, not an overrun.
- Max input rate 1 bit/cycle; no overrun if decoder latency (dec_start to dec_done) < CODE_W cycles.

## Test plan
- Reset: hold rst=0 3 cycles with random inputs → all outputs 0, busy=0.
- Collect: CODE_W=14, feed 1,0,1,1,0,0,0,0,0,0,0,0,0,1 with gaps of in_vld=0 → frame_out=14'h200D, single dec_start, frame_cnt=1.
- Serialise: dec_done with dec_code=14'h200D, dec_data=7'b1010011 → code_out 1,0,1,1,0×9,1 over 14 code_vld cycles; data_out 1,1,0,0,1,1,0,0,0,0,1,1,1,1 with data_stb on cycles 0,2,…,12.
- Overrun: second frame completes before dec_done → no dec_start, frame_out unchanged, frame_cnt=1, overrun=1 until reset.
- Simultaneous: dec_done on same edge as next completion → frame accepted, dec_start=1, frame_cnt=2, overrun=0.
- Back-to-back: continuous in_vld, 4-cycle decoder latency, 5 frames, CNT_W=2 → 5 dec_starts 14 cycles apart, frame_cnt wraps to 1, overrun=0.
